// File: rtl/count_frame_pkg.sv
// Shared types and constants for the count frame transmitter: FSM encoding,
// default header byte and the byte/index sizing derived from the count width.
package count_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_PAY,
        ST_CHK,
        ST_DONE
    } state_t;

    localparam int         DEFAULT_WIDTH  = 64;
    localparam logic [7:0] DEFAULT_HEADER = 8'hA5;
    localparam int         BYTES          = DEFAULT_WIDTH / 8;
    localparam int         IDX_W          = $clog2(2 * BYTES);

    // Payload index width for an arbitrary count width (2*width/8 bytes).
    function automatic int idx_width(input int width);
        return $clog2(2 * (width / 8));
    endfunction

endpackage

// File: rtl/count_frame_shreg.sv
// Snapshot of both counts as one 2*WIDTH-bit word; parallel load on capture,
// shift left by one byte per accepted payload byte. The top byte is the payload.
module count_frame_shreg
    import count_frame_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 load,
    input  logic                 shift,
    input  logic [2*WIDTH-1:0]   load_value,
    output logic [7:0]           top_byte,
    output logic [7:0]           next_byte
);

    logic [2*WIDTH-1:0] snap;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            snap <= '0;
        end else if (load) begin
            snap <= load_value;
        end else if (shift) begin
            snap <= {snap[2*WIDTH-9:0], 8'h00};
        end
    end

    assign top_byte  = snap[2*WIDTH-1 -: 8];
    assign next_byte = snap[2*WIDTH-9 -: 8];

endmodule

// File: rtl/count_frame_tx.sv
// Snapshots Count0/Count1 on Start and streams header, both counts MSB first
// and an XOR checksum as a byte-wide valid/ready frame with registered outputs.
module count_frame_tx
    import count_frame_pkg::*;
#(
    parameter int         WIDTH  = DEFAULT_WIDTH,
    parameter logic [7:0] HEADER = DEFAULT_HEADER
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] Count0,
    input  logic [WIDTH-1:0] Count1,
    input  logic             Ready,
    output logic [7:0]       Data,
    output logic             Valid,
    output logic             Busy,
    output logic             Done
);

    localparam int            N        = WIDTH / 8;
    localparam int            IW       = idx_width(WIDTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(2 * N - 1);

    state_t        state, state_next;
    logic [IW-1:0] idx, idx_next;
    logic [7:0]    csum, csum_next;
    logic [7:0]    data_next;
    logic          valid_next, busy_next, done_next;
    logic          load, shift;
    logic [7:0]    top_byte, next_byte;

    count_frame_shreg #(.WIDTH(WIDTH)) u_shreg (
        .Clk        (Clk),
        .Reset      (Reset),
        .load       (load),
        .shift      (shift),
        .load_value ({Count0, Count1}),
        .top_byte   (top_byte),
        .next_byte  (next_byte)
    );

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        csum_next  = csum;
        load       = 1'b0;
        shift      = 1'b0;

        case (state)
            ST_IDLE: if (Start) begin
                state_next = ST_HDR;
                load       = 1'b1;
                csum_next  = '0;
                idx_next   = '0;
            end
            ST_HDR: if (Ready) begin
                state_next = ST_PAY;
                idx_next   = '0;
            end
            ST_PAY: if (Ready) begin
                shift     = 1'b1;
                csum_next = csum ^ top_byte;
                idx_next  = idx + 1'b1;
                if (idx == LAST_IDX) state_next = ST_CHK;
            end
            ST_CHK:  if (Ready) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase

        // Outputs are computed for the state being entered so they can be registered.
        valid_next = (state_next == ST_HDR) || (state_next == ST_PAY) || (state_next == ST_CHK);
        busy_next  = (state_next != ST_IDLE);
        done_next  = (state_next == ST_DONE);

        case (state_next)
            ST_HDR:  data_next = HEADER;
            ST_PAY:  data_next = shift ? next_byte : top_byte;
            ST_CHK:  data_next = csum_next;
            default: data_next = 8'h00;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= ST_IDLE;
            idx   <= '0;
            csum  <= '0;
            Data  <= 8'h00;
            Valid <= 1'b0;
            Busy  <= 1'b0;
            Done  <= 1'b0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
            csum  <= csum_next;
            Data  <= data_next;
            Valid <= valid_next;
            Busy  <= busy_next;
            Done  <= done_next;
        end
    end

endmodule
